// File: rtl/keypad_pkg.sv
// Shared constants and FSM state type for the keypad entry block.
package keypad_pkg;

  localparam logic [3:0] KEY_BKSP   = 4'hE;
  localparam logic [3:0] KEY_CLR    = 4'hF;
  localparam int         MAX_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/keypad_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer with a registered
// rising-edge pulse that coincides with the first cycle of the new high level.
module keypad_debounce #(
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter logic RST_LEVEL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Any cycle agreeing with the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= RST_LEVEL;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_p1;
        rise  <= sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad digit entry: debounced key/enter events edit a 4-digit buffer and
// commit it to a valid/ready output register.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_DIGITS      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_code,
  input  logic        key_hit,
  input  logic        enter,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic [15:0] value,
  output logic        value_valid,
  input  logic        value_ready,
  output logic        overflow
);

  import keypad_pkg::*;

  logic [3:0]  code_p0;
  logic [3:0]  code_p1;
  logic        key_lvl;
  logic        key_rise;
  logic        ent_lvl;
  logic        ent_rise;
  logic        enter_ev;

  state_e      state;
  state_e      state_nxt;
  logic [15:0] digits_nxt;
  logic [2:0]  count_nxt;
  logic [15:0] value_nxt;
  logic        ovf_nxt;

  // Both levels come out of reset high, so a button already down at reset
  // release has to be seen released before it can produce a rising edge.
  keypad_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RST_LEVEL       (1'b1)
  ) u_key_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (key_hit),
    .level (key_lvl),
    .rise  (key_rise)
  );

  keypad_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RST_LEVEL       (1'b1)
  ) u_ent_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (enter),
    .level (ent_lvl),
    .rise  (ent_rise)
  );

  assign enter_ev = ent_rise & ent_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_p0 <= 4'h0;
      code_p1 <= 4'h0;
    end else begin
      code_p0 <= key_code;
      code_p1 <= code_p0;
    end
  end

  always_comb begin
    state_nxt  = state;
    digits_nxt = digits;
    count_nxt  = digit_count;
    value_nxt  = value;
    ovf_nxt    = 1'b0;
    case (state)
      ST_COMMIT: begin
        if (value_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE, ST_HELD: begin
        // Enter takes priority; a key arriving with it is dropped.
        if (enter_ev && (digit_count != 3'd0)) begin
          value_nxt  = digits;
          digits_nxt = 16'h0000;
          count_nxt  = 3'd0;
          state_nxt  = ST_COMMIT;
        end else if ((state == ST_IDLE) && key_rise && !enter_ev) begin
          state_nxt = ST_HELD;
          if (code_p1 == KEY_CLR) begin
            digits_nxt = 16'h0000;
            count_nxt  = 3'd0;
          end else if (code_p1 == KEY_BKSP) begin
            if (digit_count != 3'd0) begin
              digits_nxt = {4'h0, digits[15:4]};
              count_nxt  = digit_count - 3'd1;
            end
          end else if (digit_count == 3'(MAX_DIGITS)) begin
            ovf_nxt = 1'b1;
          end else begin
            digits_nxt = {digits[11:0], code_p1};
            count_nxt  = digit_count + 3'd1;
          end
        end else if ((state == ST_HELD) && !key_lvl) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      digits      <= 16'h0000;
      digit_count <= 3'd0;
      value       <= 16'h0000;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      digits      <= digits_nxt;
      digit_count <= count_nxt;
      value       <= value_nxt;
      overflow    <= ovf_nxt;
    end
  end

  assign value_valid = (state == ST_COMMIT);

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
REQ-002 Parameter MAX_DIGITS, fixed at 4, is the digit-buffer depth.
REQ-003 Port clk, input, 1 bit: sole clock, rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port key_code, input, 4 bits: code of the pressed key from the keypad scanner.
REQ-006 Port key_hit, input, 1 bit: high while any key is detected down.
REQ-007 Port enter, input, 1 bit: raw enter pushbutton.
REQ-008 Port digits, output, 16 bits: live entry; the newest digit is in [3:0] and the oldest in [15:12].
REQ-009 Port digit_count, output, 3 bits: number of digits held, 0 to 4.
REQ-010 Port value, output, 16 bits: committed entry.
REQ-011 Port value_valid, output, 1 bit: value is pending.
REQ-012 Port value_ready, input, 1 bit: consumer accepts value.
REQ-013 Port overflow, output, 1 bit: one-cycle pulse when a digit is dropped.

Function
REQ-014 key_hit, key_code and enter SHALL each pass through a 2-flop synchronizer before use.
REQ-015 The debounced level SHALL toggle only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle resets the counter to 0.
REQ-016 A key press event SHALL be the debounced key_hit 0->1 edge; key_code SHALL be sampled from the synchronized code in that same cycle.
REQ-017 An enter event SHALL be the debounced enter 0->1 edge.
REQ-018 State machine states: IDLE (accept events), HELD (key accepted, wait for debounced release), COMMIT (value_valid high).
REQ-019 IDLE->HELD on a key event; HELD->IDLE on debounced key_hit falling; IDLE or HELD->COMMIT on an enter event with digit_count>0; COMMIT->IDLE in the cycle value_valid&&value_ready.
REQ-020 Codes 0x0-0xD SHALL be digits: digits<={digits[11:0],code} and digit_count+1, one cycle after the event.
REQ-021 Code 0xE (backspace) SHALL apply digits<={4'h0,digits[15:4]} and digit_count-1; when digit_count==0 it SHALL be a no-op.
REQ-022 Code 0xF (clear) SHALL set digits=0 and digit_count=0.
REQ-023 A digit event with digit_count==4 SHALL leave digits unchanged and pulse overflow for exactly 1 cycle.
REQ-024 On commit, value<=digits, value_valid<=1, digits<=0 and digit_count<=0, all in the same cycle.
REQ-025 Enter with digit_count==0 SHALL be ignored.
REQ-026 value and value_valid SHALL stay stable until the handshake completes; a key or enter event in COMMIT SHALL be dropped without an overflow pulse.
REQ-027 If a key event and an enter event occur in the same cycle, enter SHALL win and the key SHALL be dropped.
REQ-028 A key still held at reset release SHALL need a debounced release before it can be accepted.
REQ-029 Latency from a stable key_hit change to the digits update SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-030 rst_n low SHALL asynchronously clear digits, digit_count, value, value_valid, overflow, all counters and all synchronizers, and set the state to IDLE.
REQ-031 Reset asserted mid-entry or during COMMIT SHALL discard all pending data; no handshake completes.

Structure
REQ-032 Package keypad_pkg SHALL hold the KEY_BKSP=4'hE and KEY_CLR=4'hF constants, the MAX_DIGITS constant, and the state enum.
REQ-033 Sub-module keypad_debounce (synchronizer, counter, level and rise output) SHALL be instantiated twice, once for key_hit and once for enter.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Press 0x1, 0x2, 0x3 with a clean press and release each -> digits=16'h0123, digit_count=3.
REQ-035 key_hit glitch of 3 cycles -> no change to digits or state.
REQ-036 Five digits 1-5 -> digits=16'h1234, digit_count=4, exactly one overflow pulse.
REQ-037 Entry 0x7, 0x8, then 0xE -> digits=16'h0007; then 0xF -> digits=0, digit_count=0; then 0xE -> still 0.
REQ-038 Entry 0x4, 0x2, enter, value_ready low for 10 cycles -> value=16'h0042 with value_valid held throughout and a key press dropped; ready high -> value_valid 0 on the next cycle.
REQ-039 rst_n low during COMMIT -> value_valid=0 immediately, state IDLE, digit_count=0.
